// File: rtl/lcd_frame_sequencer_if.sv
// Host/controller signal bundle for lcd_frame_sequencer.
// master: the sequencer side (drives controller op port and status).
// slave : the environment side (host writes, controller rdy).
interface lcd_frame_sequencer_if #(
  parameter int NCOMMANDS = 3
);
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [7:0]           wr_data;
  logic                 refresh;
  logic                 lcd_rdy;
  logic [NCOMMANDS:0]   op_out;
  logic [7:0]           data_out;
  logic                 enable_out;
  logic                 busy;
  logic                 frame_done;
  logic                 err;

  modport master (
    input  wr_en, wr_addr, wr_data, refresh, lcd_rdy,
    output op_out, data_out, enable_out, busy, frame_done, err
  );

  modport slave (
    output wr_en, wr_addr, wr_data, refresh, lcd_rdy,
    input  op_out, data_out, enable_out, busy, frame_done, err
  );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: owns a 2x16 character frame buffer and repaints it on an
// L1602A controller via the op/enable/rdy handshake (INIT, CLEAR once; then
// CMD 80 + 16 WRITE + CMD C0 + 16 WRITE per dirty frame).
// Optional feature macro: LCD_SEQ_AUTOREFRESH_EN (periodic repaint from IDLE).
//
// state   | meaning
// S_INIT  | issue INIT op after reset
// S_CLR   | issue CLEAR op
// S_IDLE  | wait for dirty/refresh
// S_ADDR0 | CMD 8'h80 (line 0 address)
// S_LINE0 | WRITE buf[0..15]
// S_ADDR1 | CMD 8'hC0 (line 1 address)
// S_LINE1 | WRITE buf[16..31]
// S_DONE  | frame_done pulse
// Each op state runs a sub-phase: ISSUE (wait rdy, strobe) -> ACK (wait rdy low,
// with timeout) -> DONE (wait rdy high, advance).
module lcd_frame_sequencer #(
  parameter int NCOMMANDS      = 3,
  parameter int ACK_TMO        = 4095,
  parameter int REFRESH_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_frame_sequencer_if.master bus
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_ADDR0 = 3'd3;
  localparam logic [2:0] S_LINE0 = 3'd4;
  localparam logic [2:0] S_ADDR1 = 3'd5;
  localparam logic [2:0] S_LINE1 = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] PH_ISSUE = 2'd0;
  localparam logic [1:0] PH_ACK   = 2'd1;
  localparam logic [1:0] PH_DONE  = 2'd2;

  localparam logic [NCOMMANDS:0] OP_INIT  = {{NCOMMANDS{1'b0}}, 1'b1};
  localparam logic [NCOMMANDS:0] OP_WRITE = OP_INIT << 1;
  localparam logic [NCOMMANDS:0] OP_CLEAR = OP_INIT << 2;
  localparam logic [NCOMMANDS:0] OP_CMD   = OP_INIT << 3;

  logic [7:0]           fbuf_q [32];
  logic [2:0]           state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [4:0]           idx_q, idx_d;
  logic [11:0]          tmo_q, tmo_d;
  logic [NCOMMANDS:0]   op_q, op_d;
  logic [7:0]           data_q, data_d;
  logic                 en_q, en_d;
  logic                 err_q, err_d;
  logic                 dirty_q, dirty_d;
  logic                 dirty_clr;
  logic                 abort;
  logic                 ar_hit;
  logic [NCOMMANDS:0]   cur_op;
  logic [7:0]           cur_data;

  assign bus.op_out     = op_q;
  assign bus.data_out   = data_q;
  assign bus.enable_out = en_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);

  // Frame buffer: host writes land on the same edge in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) fbuf_q[i] <= 8'h20;
    end else if (bus.wr_en) begin
      fbuf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef LCD_SEQ_AUTOREFRESH_EN
  logic [20:0] ar_q, ar_d;

  // Idle-time counter; zero outside IDLE so it restarts on every IDLE entry.
  always_comb begin
    ar_d = (state_q == S_IDLE) ? ar_q + 21'd1 : 21'd0;
  end

  assign ar_hit = (state_q == S_IDLE) && (ar_q == 21'(REFRESH_CYCLES - 1));

  // Autorefresh counter register.
  always_ff @(posedge clk) begin
    if (rst) ar_q <= '0;
    else     ar_q <= ar_d;
  end
`else
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = (REFRESH_CYCLES != 0);
  assign ar_hit = 1'b0;
`endif

  // Op and operand belonging to the current op state; buffer read at issue time.
  always_comb begin
    cur_op   = '0;
    cur_data = 8'h00;
    case (state_q)
      S_INIT:  cur_op = OP_INIT;
      S_CLR:   cur_op = OP_CLEAR;
      S_ADDR0: begin cur_op = OP_CMD;   cur_data = 8'h80;          end
      S_ADDR1: begin cur_op = OP_CMD;   cur_data = 8'hC0;          end
      S_LINE0,
      S_LINE1: begin cur_op = OP_WRITE; cur_data = fbuf_q[idx_q];  end
      default: ;
    endcase
  end

  // Sequencer next-state: frame FSM plus per-op handshake phases.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    op_d      = op_q;
    data_d    = data_q;
    en_d      = 1'b0;
    err_d     = err_q;
    dirty_clr = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dirty_q || bus.refresh) begin
          dirty_clr = 1'b1;
          state_d   = S_ADDR0;
          phase_d   = PH_ISSUE;
          idx_d     = 5'd0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        case (phase_q)
          PH_ISSUE: begin
            if (bus.lcd_rdy) begin
              op_d    = cur_op;
              data_d  = cur_data;
              en_d    = 1'b1;
              tmo_d   = 12'd0;
              phase_d = PH_ACK;
            end
          end
          PH_ACK: begin
            if (!bus.lcd_rdy) begin
              phase_d = PH_DONE;
              tmo_d   = 12'd0;
            end else if (tmo_q == 12'(ACK_TMO - 1)) begin
              // Controller never took the op: flag it and retry the whole frame.
              err_d   = 1'b1;
              abort   = 1'b1;
              state_d = S_IDLE;
              phase_d = PH_ISSUE;
              op_d    = '0;
              data_d  = 8'h00;
              tmo_d   = 12'd0;
            end else begin
              tmo_d = tmo_q + 12'd1;
            end
          end
          default: begin
            if (bus.lcd_rdy) begin
              phase_d = PH_ISSUE;
              op_d    = '0;
              data_d  = 8'h00;
              case (state_q)
                S_INIT:  state_d = S_CLR;
                S_CLR:   state_d = S_IDLE;
                S_ADDR0: state_d = S_LINE0;
                S_ADDR1: state_d = S_LINE1;
                S_LINE0: begin
                  idx_d = idx_q + 5'd1;
                  if (idx_q == 5'd15) state_d = S_ADDR1;
                end
                S_LINE1: begin
                  idx_d = idx_q + 5'd1;
                  if (idx_q == 5'd31) state_d = S_DONE;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    endcase
    // Set sources win over the IDLE clear; refresh in IDLE is consumed directly.
    dirty_d = (dirty_q & ~dirty_clr) | bus.wr_en | (bus.refresh & (state_q != S_IDLE))
            | abort | ar_hit;
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      phase_q <= PH_ISSUE;
      idx_q   <= 5'd0;
      tmo_q   <= 12'd0;
      op_q    <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      dirty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      data_q  <= data_d;
      en_q    <= en_d;
      err_q   <= err_d;
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench for lcd_frame_sequencer: behavioural controller model with
// random busy lengths, op log, and a frame-buffer reference model.
module tb_lcd_frame_sequencer;
  localparam int TMO = 60;

  localparam logic [3:0] C_INIT  = 4'b0001;
  localparam logic [3:0] C_WRITE = 4'b0010;
  localparam logic [3:0] C_CLEAR = 4'b0100;
  localparam logic [3:0] C_CMD   = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #25 clk = ~clk;

  lcd_frame_sequencer_if #(.NCOMMANDS(3)) bus ();

  lcd_frame_sequencer #(.NCOMMANDS(3), .ACK_TMO(TMO), .REFRESH_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  tb_buf [32];
  logic [11:0] log_q [$];
  int          fd_count = 0;
  int          cyc = 0;
  int          en_cyc = 0;
  int          rdy_cnt = 0;
  bit          stuck = 1'b0;

  // Controller model and monitor, sampling 1 unit after the active edge.
  initial begin
    bus.lcd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.frame_done === 1'b1) fd_count++;
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) bus.lcd_rdy = 1'b1;
      end
      if (bus.enable_out === 1'b1) begin
        log_q.push_back({bus.op_out, bus.data_out});
        en_cyc = cyc;
        if (!stuck) begin
          bus.lcd_rdy = 1'b0;
          rdy_cnt = int'($urandom_range(1, 4));
        end
      end
    end
  end

  initial begin
    #(50 * 90000);
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tb_buf[a] = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_refresh();
    bus.refresh = 1'b1;
    tick();
    bus.refresh = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int stable = 0;
    int n = 0;
    while (stable < 5 && n < bound) begin
      tick(); n++;
      if (bus.busy === 1'b0 && bus.lcd_rdy === 1'b1) stable++;
      else stable = 0;
    end
    chk(tag, 32'(stable), 32'd5);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int bound);
    int n = 0;
    while (log_q.size() < cnt && n < bound) begin tick(); n++; end
    chk(tag, 32'(log_q.size() >= cnt), 32'd1);
  endtask

  // Expected repaint sequence computed from the buffer model.
  task automatic chk_frame(input string tag, input int base);
    logic [11:0] e;
    if (log_q.size() < base + 34) begin
      chk({tag, "_len"}, 32'(log_q.size()), 32'(base + 34));
    end else begin
      for (int i = 0; i < 34; i++) begin
        if (i == 0)       e = {C_CMD, 8'h80};
        else if (i == 17) e = {C_CMD, 8'hC0};
        else if (i < 17)  e = {C_WRITE, tb_buf[i - 1]};
        else              e = {C_WRITE, tb_buf[i - 2]};
        chk($sformatf("%s[%0d]", tag, i), 32'(log_q[base + i]), 32'(e));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op"},    32'(bus.op_out),     32'd0);
    chk({tag, "_data"},  32'(bus.data_out),   32'd0);
    chk({tag, "_en"},    32'(bus.enable_out), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),       32'd1);
    chk({tag, "_fd"},    32'(bus.frame_done), 32'd0);
    chk({tag, "_err"},   32'(bus.err),        32'd0);
  endtask

  initial begin
    int n;
    int dur;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.refresh = 1'b0;
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;

    // Reset and power-up sequence.
    tick(); tick();
    chk_reset_outputs("reset");
    log_q.delete(); fd_count = 0;
    rst = 1'b0;
    wait_idle("init_idle", 2000);
    chk("init_len",   32'(log_q.size()), 32'd36);
    chk("init_op0",   32'(log_q[0][11:8]), 32'(C_INIT));
    chk("init_op1",   32'(log_q[1][11:8]), 32'(C_CLEAR));
    chk_frame("init_frame", 2);
    chk("init_fd",    32'(fd_count), 32'd1);
    chk("init_busy",  32'(bus.busy), 32'd0);

    // Directed writes at both ends of the buffer.
    log_q.delete(); fd_count = 0;
    wr(5'd0, 8'h41);
    wr(5'd31, 8'h5A);
    wait_idle("az_idle", 2000);
    chk("az_first", 32'(log_q[1]),  32'({C_WRITE, 8'h41}));
    chk("az_last",  32'(log_q[33]), 32'({C_WRITE, 8'h5A}));
    chk_frame("az_frame", log_q.size() - 34);

    // Random write bursts against the buffer model.
    for (int r = 0; r < 3; r++) begin
      log_q.delete(); fd_count = 0;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        wr(5'($urandom_range(0, 31)), 8'($urandom_range(32, 126)));
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle($sformatf("rnd%0d_idle", r), 3000);
      chk($sformatf("rnd%0d_whole", r), 32'((log_q.size() % 34 == 0) && (fd_count > 0)), 32'd1);
      chk_frame($sformatf("rnd%0d_frame", r), log_q.size() - 34);
    end

    // Idle with no writes: repaint only with autorefresh compiled in.
    log_q.delete();
    repeat (300) tick();
`ifdef LCD_SEQ_AUTOREFRESH_EN
    chk("autorefresh", 32'(log_q.size() > 0), 32'd1);
    wait_idle("ar_idle", 3000);
`else
    chk("no_autorefresh", 32'(log_q.size()), 32'd0);
`endif

    // Write to an unsent char mid-frame: shows this frame and re-arms another.
    log_q.delete(); fd_count = 0;
    pulse_refresh();
    wait_log("q_reach3", 5, 500);
    wr(5'd20, 8'h51);
    wait_idle("q_idle", 3000);
    chk("q_frames", 32'(fd_count), 32'd2);
    chk("q_first",  32'(log_q[22]), 32'({C_WRITE, 8'h51}));
    chk_frame("q_second", 34);

    // Refresh while busy is latched and served afterwards.
    log_q.delete(); fd_count = 0;
    pulse_refresh();
    wait_log("rb_reach", 10, 500);
    pulse_refresh();
    wait_idle("rb_idle", 3000);
    chk("rb_frames", 32'(fd_count), 32'd2);

    // Acknowledge timeout.
    chk("tmo_err_before", 32'(bus.err), 32'd0);
    stuck = 1'b1;
    pulse_refresh();
    n = 0;
    while (bus.err !== 1'b1 && n < TMO + 100) begin tick(); n++; end
    dur = cyc - en_cyc;
    chk("tmo_err",    32'(bus.err),    32'd1);
    chk("tmo_cycles", 32'(dur),        32'(TMO));
    chk("tmo_idle",   32'(bus.busy),   32'd0);
    chk("tmo_op",     32'(bus.op_out), 32'd0);
    stuck = 1'b0;
    fd_count = 0;
    wait_idle("tmo_recover", 3000);
    chk("tmo_retry_fd", 32'(fd_count > 0), 32'd1);
    chk("tmo_sticky",   32'(bus.err), 32'd1);

    // Reset in the middle of line 0.
    log_q.delete();
    pulse_refresh();
    wait_log("rst_reach10", 12, 500);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    log_q.delete(); fd_count = 0;
    rst = 1'b0;
    wait_idle("midrst_idle", 3000);
    chk("midrst_len", 32'(log_q.size()), 32'd36);
    chk("midrst_op0", 32'(log_q[0][11:8]), 32'(C_INIT));
    chk_frame("midrst_frame", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
